// File: rtl/strap_sampler_if.sv
// Strap sampler signal bundle: strap levels and resample request in,
// latched strap value and status out.
interface strap_sampler_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] strap_in;
  logic             resample;
  logic [WIDTH-1:0] strap_out;
  logic             strap_valid;
  logic             strap_err;
  logic             busy;

  modport master (
    output strap_in, resample,
    input  strap_out, strap_valid, strap_err, busy
  );

  modport slave (
    input  strap_in, resample,
    output strap_out, strap_valid, strap_err, busy
  );
endinterface

// File: rtl/strap_sampler.sv
// Strap sampler: waits SETTLE cycles, then requires SAMPLES identical
// consecutive samples of the straps, restarting on mismatch up to RETRIES times.
module strap_sampler #(
  parameter int WIDTH   = 4,
  parameter int SETTLE  = 8,
  parameter int SAMPLES = 4,
  parameter int RETRIES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  strap_sampler_if.slave  bus
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = $clog2(SAMPLES + 1);
  localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE,
    ST_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] strap_out_q, strap_out_d;
  logic             strap_valid_q, strap_valid_d;
  logic             strap_err_q, strap_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SETTLE;
      settle_cnt_q  <= '0;
      sample_cnt_q  <= '0;
      retry_q       <= '0;
      ref_q         <= '0;
      strap_out_q   <= '0;
      strap_valid_q <= 1'b0;
      strap_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      sample_cnt_q  <= sample_cnt_d;
      retry_q       <= retry_d;
      ref_q         <= ref_d;
      strap_out_q   <= strap_out_d;
      strap_valid_q <= strap_valid_d;
      strap_err_q   <= strap_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    sample_cnt_d  = sample_cnt_q;
    retry_d       = retry_q;
    ref_d         = ref_q;
    strap_out_d   = strap_out_q;
    strap_valid_d = strap_valid_q;
    strap_err_d   = strap_err_q;

    case (state_q)
      ST_SETTLE: begin
        if (settle_cnt_q == SW'(SETTLE - 1)) begin
          state_d      = ST_SAMPLE;
          settle_cnt_d = '0;
          sample_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (sample_cnt_q == '0) begin
          ref_d        = bus.strap_in;
          sample_cnt_d = CW'(1);
        end else if (bus.strap_in == ref_q) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (sample_cnt_q == CW'(SAMPLES - 1)) begin
            state_d       = ST_DONE;
            strap_out_d   = ref_q;
            strap_valid_d = 1'b1;
          end
        end else if (retry_q < RW'(RETRIES)) begin
          // The mismatching value becomes the new reference and counts as the first sample.
          ref_d        = bus.strap_in;
          sample_cnt_d = CW'(1);
          retry_d      = retry_q + 1'b1;
        end else begin
          state_d     = ST_ERR;
          strap_err_d = 1'b1;
          strap_out_d = '0;
        end
      end

      ST_DONE, ST_ERR: begin
        if (bus.resample) begin
          state_d       = ST_SETTLE;
          settle_cnt_d  = '0;
          sample_cnt_d  = '0;
          retry_d       = '0;
          strap_valid_d = 1'b0;
          strap_err_d   = 1'b0;
        end
      end

      default: state_d = ST_SETTLE;
    endcase
  end

  assign bus.strap_out   = strap_out_q;
  assign bus.strap_valid = strap_valid_q;
  assign bus.strap_err   = strap_err_q;
  assign bus.busy        = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

endmodule

// File: tb/tb_strap_sampler.sv
// Self-checking bench for strap_sampler: directed scenarios plus randomized
// strap sequences checked edge by edge against a run-length reference model.
module tb_strap_sampler;

  localparam int WIDTH   = 4;
  localparam int SETTLE  = 8;
  localparam int SAMPLES = 4;
  localparam int RETRIES = 3;
  localparam int SEQ_LEN = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  strap_sampler_if #(.WIDTH(WIDTH)) bus ();

  strap_sampler #(
    .WIDTH(WIDTH), .SETTLE(SETTLE), .SAMPLES(SAMPLES), .RETRIES(RETRIES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // seq[e] is the strap value presented for edge e of a run (edge 1 = settle cycle 0)
  logic [WIDTH-1:0] seq [SEQ_LEN];
  int               resample_at = 0;
  logic [WIDTH-1:0] cur_out = '0;

  // Runs of identical samples: a run must last SAMPLES values; a differing value
  // starts a new run, and more than RETRIES such breaks is an error.
  function automatic void model(output int end_edge, output bit is_err,
                                output logic [WIDTH-1:0] val);
    int s = 0;
    int misses = 0;
    int base = SETTLE + 1;
    bit restart;
    end_edge = 0;
    is_err   = 1'b0;
    val      = '0;
    for (int run = 0; run <= RETRIES; run++) begin
      restart = 1'b0;
      for (int j = 1; j < SAMPLES && !restart; j++) begin
        if (seq[base + s + j] !== seq[base + s]) begin
          misses++;
          if (misses > RETRIES) begin
            is_err   = 1'b1;
            end_edge = base + s + j;
            return;
          end
          s       = s + j;
          restart = 1'b1;
        end
      end
      if (!restart) begin
        end_edge = base + s + SAMPLES - 1;
        val      = seq[base + s];
        return;
      end
    end
  endfunction

  task automatic fill_const(input logic [WIDTH-1:0] v);
    for (int e = 0; e < SEQ_LEN; e++) seq[e] = v;
  endtask

  task automatic apply_reset();
    bus.resample = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    cur_out = '0;
  endtask

  // Pulses resample from DONE/ERR and checks the first cycle back in SETTLE.
  task automatic start_resample(input string name);
    @(negedge clk);
    bus.resample = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.strap_valid, bus.strap_err} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL %s resample status busy/valid/err got %b%b%b expected 100",
               name, bus.busy, bus.strap_valid, bus.strap_err);
    end
    checks++;
    if (bus.strap_out !== cur_out) begin
      errors++;
      $display("[TB] FAIL %s resample hold strap_out got %b expected %b",
               name, bus.strap_out, cur_out);
    end
    @(negedge clk);
    bus.resample = 1'b0;
  endtask

  // Drives seq edge by edge from the current start point and checks every edge.
  task automatic run_check(input string name, output int end_edge, output bit is_err);
    logic [WIDTH-1:0] val;
    logic [2:0]       exp_st;
    logic [WIDTH-1:0] exp_out;
    model(end_edge, is_err, val);
    for (int e = 1; e <= end_edge + 4; e++) begin
      bus.strap_in = seq[e];
      bus.resample = (e == resample_at);
      @(posedge clk);
      #1;
      if (e < end_edge) begin
        exp_st  = 3'b100;
        exp_out = cur_out;
      end else begin
        exp_st  = is_err ? 3'b001 : 3'b010;
        exp_out = is_err ? '0 : val;
      end
      checks++;
      if ({bus.busy, bus.strap_valid, bus.strap_err} !== exp_st) begin
        errors++;
        $display("[TB] FAIL %s edge %0d busy/valid/err got %b%b%b expected %b",
                 name, e, bus.busy, bus.strap_valid, bus.strap_err, exp_st);
      end
      checks++;
      if (bus.strap_out !== exp_out) begin
        errors++;
        $display("[TB] FAIL %s edge %0d strap_out got %b expected %b",
                 name, e, bus.strap_out, exp_out);
      end
      @(negedge clk);
    end
    bus.resample = 1'b0;
    resample_at  = 0;
    cur_out      = is_err ? '0 : val;
  endtask

  task automatic check_end(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s completion edge got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    int  end_edge;
    bit  is_err;
    bus.strap_in = 4'b1010;
    bus.resample = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.strap_valid, bus.strap_err, bus.strap_out} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_state got busy/valid/err/out %b%b%b%b expected 1000000",
               bus.busy, bus.strap_valid, bus.strap_err, bus.strap_out);
    end
    apply_reset();
    fill_const(4'b1010);
    run_check("nominal", end_edge, is_err);
    check_end("nominal", end_edge, 12);
  endtask

  task automatic test_reset_in_done();
    int end_edge;
    bit is_err;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.strap_valid, bus.strap_err, bus.strap_out} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_in_done got busy/valid/err/out %b%b%b%b expected 1000000",
               bus.busy, bus.strap_valid, bus.strap_err, bus.strap_out);
    end
    apply_reset();
    run_check("after_reset_in_done", end_edge, is_err);
    check_end("after_reset_in_done", end_edge, 12);
  endtask

  task automatic test_retry();
    int end_edge;
    bit is_err;
    apply_reset();
    fill_const(4'b1011);
    for (int e = 0; e <= 10; e++) seq[e] = 4'b1010;
    run_check("retry", end_edge, is_err);
    check_end("retry", end_edge, 14);
    checks++;
    if (cur_out !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL retry_value model got %b expected 1011", cur_out);
    end
  endtask

  task automatic test_error();
    int end_edge;
    bit is_err;
    apply_reset();
    for (int e = 0; e < SEQ_LEN; e++) seq[e] = 4'(e);
    run_check("error", end_edge, is_err);
    check_end("error", end_edge, 13);
  endtask

  task automatic test_resample_done();
    int end_edge;
    bit is_err;
    apply_reset();
    fill_const(4'b1010);
    run_check("pre_resample", end_edge, is_err);
    fill_const(4'b0101);
    bus.strap_in = 4'b0101;
    start_resample("resample_done");
    run_check("resample_done", end_edge, is_err);
    check_end("resample_done", end_edge, 12);
  endtask

  task automatic test_resample_settle();
    int end_edge;
    bit is_err;
    apply_reset();
    fill_const(4'b1010);
    resample_at = 3;
    run_check("resample_settle", end_edge, is_err);
    check_end("resample_settle", end_edge, 12);
  endtask

  task automatic test_reset_midway();
    int end_edge;
    bit is_err;
    apply_reset();
    fill_const(4'b1010);
    for (int e = 1; e <= 10; e++) begin
      bus.strap_in = seq[e];
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.strap_valid, bus.strap_err, bus.strap_out} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_midway got busy/valid/err/out %b%b%b%b expected 1000000",
               bus.busy, bus.strap_valid, bus.strap_err, bus.strap_out);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("reset_midway", end_edge, is_err);
    check_end("reset_midway", end_edge, 12);
  endtask

  task automatic test_random();
    int end_edge;
    bit is_err;
    int pct;
    logic [WIDTH-1:0] v;
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(3))
        0:       pct = 0;
        1:       pct = 10;
        2:       pct = 30;
        default: pct = 90;
      endcase
      v = WIDTH'($urandom);
      for (int e = 0; e < SEQ_LEN; e++) begin
        if ($urandom_range(99) < pct) v = WIDTH'($urandom);
        seq[e] = v;
      end
      resample_at = ($urandom_range(1) == 1) ? $urandom_range(SETTLE, 1) : 0;
      if ($urandom_range(1) == 1) begin
        apply_reset();
      end else begin
        bus.strap_in = seq[0];
        start_resample("random_resample");
      end
      run_check("random", end_edge, is_err);
    end
  endtask

  initial begin
    bus.strap_in = '0;
    bus.resample = 1'b0;
    test_reset();
    test_reset_in_done();
    test_retry();
    test_error();
    test_resample_done();
    test_resample_settle();
    test_reset_midway();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/strap_sampler.md
STRAP_SAMPLER -- requirements
Module: strap_sampler

Interface
REQ-001 Parameter WIDTH, default 4, number of strap bits sampled.
REQ-002 Parameter SETTLE, default 8, number of cycles waited before the first sample (range 1..255).
REQ-003 Parameter SAMPLES, default 4, number of consecutive identical samples required (range 2..15).
REQ-004 Parameter RETRIES, default 3, number of mismatch restarts tolerated before error (range 0..7).
REQ-005 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port strap_in, input, WIDTH, quasi-static strap levels, normally tie-hi/tie-lo driven.
REQ-008 Port resample, input, 1, single-cycle request to re-run the sampling sequence.
REQ-009 Port strap_out, output, WIDTH, latched strap value.
REQ-010 Port strap_valid, output, 1, strap_out holds an agreed value.
REQ-011 Port strap_err, output, 1, sticky; sampling failed after RETRIES restarts.
REQ-012 Port busy, output, 1, high in the SETTLE and SAMPLE states.

Function
REQ-013 The FSM SHALL have states SETTLE, SAMPLE, DONE and ERR; the reset state is SETTLE.
REQ-014 SETTLE: settle counter increments each cycle from 0; at count SETTLE-1 -> SAMPLE, sample counter=0, settle counter cleared.
REQ-015 SAMPLE, sample counter 0: capture strap_in into ref register; counter -> 1.
REQ-016 SAMPLE, counter k>0, strap_in==ref: counter+1; if k==SAMPLES-1 -> DONE, strap_out<=ref, strap_valid<=1 on the same edge.
REQ-017 SAMPLE, counter k>0, strap_in!=ref, retry count<RETRIES: ref<=strap_in, counter<=1, retry count+1; state stays SAMPLE.
REQ-018 SAMPLE, mismatch with retry count==RETRIES: -> ERR, strap_err<=1, strap_out<=0, strap_valid stays 0.
REQ-019 Latency: with strap_in stable, strap_valid SHALL rise on the (SETTLE+SAMPLES)th rising edge after rst_n deasserts; each mismatch adds (k) cycles, where k is the counter value at the mismatch.
REQ-020 DONE: strap_out and strap_valid hold; strap_in changes are ignored.
REQ-021 resample in DONE or ERR: -> SETTLE on the next edge; clears strap_valid, strap_err, retry count and counters; strap_out holds its old value until the next DONE/ERR update.
REQ-022 resample in SETTLE or SAMPLE SHALL be ignored; it is not queued.
REQ-023 busy SHALL be combinationally decoded from state (1 in SETTLE/SAMPLE, 0 in DONE/ERR).
REQ-024 strap_valid and strap_err SHALL never be 1 simultaneously.
REQ-025 Counter widths SHALL hold the parameter maxima without wrap; no counter SHALL wrap in any reachable state.

Reset
REQ-026 rst_n low SHALL immediately force state=SETTLE, all counters=0, retry=0, ref=0, strap_out=0, strap_valid=0, strap_err=0, busy=1.
REQ-027 rst_n asserted mid-SAMPLE or in DONE SHALL abort and discard the sequence; after release, the full SETTLE+SAMPLES sequence restarts.
REQ-028 The first rising edge with rst_n high counts as settle cycle 0.

Verification
REQ-029 Defaults, strap_in=4'b1010 constant, release reset -> busy 1 for 12 edges, strap_valid=1 and strap_out=4'b1010 after edge 12, strap_err=0.
REQ-030 strap_in toggles 1010->1011 at sample counter 2, then stable -> one retry, strap_valid after edge 14, strap_out=4'b1011.
REQ-031 strap_in changes every cycle during SAMPLE -> 4th mismatch enters ERR; strap_err=1, strap_out=0, strap_valid=0, busy=0.
REQ-032 In DONE with strap_out=1010, set strap_in=0101 and pulse resample -> busy high next cycle, strap_valid low, after 12 more edges strap_out=0101.
REQ-033 Pulse resample during SETTLE -> no effect; valid at edge 12 as in REQ-029.
REQ-034 Assert rst_n low at edge 10, release at edge 11 -> outputs zero asynchronously; strap_valid after 12 edges from the release.
